// File: rtl/tree_scan_pkg.sv
// Shared definitions for the chunked selection-tree scan controller:
// state encoding and small sizing helpers.
package tree_scan_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  function automatic int chunk_count(input int num, input int chunk);
    return num / chunk;
  endfunction

  // Counter/index widths never collapse to zero bits.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tree_scan_ctrl_chunk_select.sv
// Combinational priority selector: lowest entry with bit0==0 wins,
// otherwise the last entry of the chunk is passed through with hit=0.
module chunk_select
  import tree_scan_pkg::*;
#(
  parameter int CHUNK = 8,
  parameter int LEN   = 16,
  localparam int LW   = clog2_min1(CHUNK)
) (
  input  logic [CHUNK*LEN-1:0] i_entries,
  output logic [LEN-1:0]       o_value,
  output logic [LW-1:0]        o_local_idx,
  output logic                 o_hit
);

  logic [LEN-1:0] w_ent [CHUNK];

  genvar gi;
  generate
    for (gi = 0; gi < CHUNK; gi++) begin : g_unpack
      assign w_ent[gi] = i_entries[gi*LEN +: LEN];
    end
  endgenerate

  // Walk downwards so the lowest matching entry is the last assignment.
  always_comb begin
    o_value     = w_ent[CHUNK-1];
    o_local_idx = LW'(CHUNK-1);
    o_hit       = 1'b0;
    for (int i = CHUNK-1; i >= 0; i--) begin
      if (!w_ent[i][0]) begin
        o_value     = w_ent[i];
        o_local_idx = LW'(i);
        o_hit       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tree_scan_ctrl.sv
// Time-multiplexed selection reduction: one CHUNK-wide selector scans a
// snapshotted NUM-entry vector, stopping at the first chunk with a hit.
module tree_scan_ctrl
  import tree_scan_pkg::*;
#(
  parameter int NUM   = 64,
  parameter int LEN   = 16,
  parameter int CHUNK = 8,
  parameter int IDXW  = $clog2(NUM)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [NUM*LEN-1:0] in,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LEN-1:0]     sum,
  output logic [IDXW-1:0]    idx,
  output logic               found,
  output logic               busy
);

  localparam int NCH = chunk_count(NUM, CHUNK);
  localparam int KW  = clog2_min1(NCH);
  localparam int LW  = clog2_min1(CHUNK);
  localparam int CW  = $clog2(CHUNK);

  logic [1:0]         r_state;
  logic [1:0]         w_next_state;
  logic [KW-1:0]      r_k;
  logic [NUM*LEN-1:0] r_snap;
  logic [LEN-1:0]     r_sum;
  logic [IDXW-1:0]    r_idx;
  logic               r_found;

  logic [CHUNK*LEN-1:0] w_chunks [NCH];
  logic [CHUNK*LEN-1:0] w_cur;
  logic [LEN-1:0]       w_value;
  logic [LW-1:0]        w_loc;
  logic                 w_hit;
  logic                 w_done;
  logic [IDXW-1:0]      w_idx;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_chunk
      assign w_chunks[gi] = r_snap[gi*CHUNK*LEN +: CHUNK*LEN];
    end
  endgenerate

  assign w_cur = w_chunks[r_k];

  chunk_select #(
    .CHUNK (CHUNK),
    .LEN   (LEN)
  ) u_chunk_select (
    .i_entries   (w_cur),
    .o_value     (w_value),
    .o_local_idx (w_loc),
    .o_hit       (w_hit)
  );

  // k*CHUNK is a pure shift, so the global index is base OR local offset.
  assign w_idx  = (IDXW'(r_k) << CW) | IDXW'(w_loc);
  assign w_done = w_hit || (r_k == KW'(NCH-1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start)     w_next_state = S_SCAN;
      S_SCAN:  if (w_done)    w_next_state = S_HOLD;
      S_HOLD:  if (out_ready) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_HOLD);
    busy      = (r_state == S_SCAN) || (r_state == S_HOLD);
  end

  // Snapshot contents are don't-care after reset, so it carries no reset.
  always_ff @(posedge clk) begin
    if (!rst && r_state == S_IDLE && start) begin
      r_snap <= in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_k     <= '0;
      r_sum   <= '0;
      r_idx   <= '0;
      r_found <= 1'b0;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_k <= '0;
      end else if (r_state == S_SCAN) begin
        if (w_done) begin
          r_sum   <= w_value;
          r_idx   <= w_idx;
          r_found <= w_hit;
        end else begin
          r_k <= r_k + 1'b1;
        end
      end
    end
  end

  assign sum   = r_sum;
  assign idx   = r_idx;
  assign found = r_found;

endmodule

// File: tb/tb_tree_scan_ctrl.sv
// Randomized and directed bench for tree_scan_ctrl against a behavioural
// model of "first even entry, else the last entry".
module tb_tree_scan_ctrl;

  localparam int NUM   = 64;
  localparam int LEN   = 16;
  localparam int CHUNK = 8;
  localparam int IDXW  = $clog2(NUM);

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [NUM*LEN-1:0] in_vec;
  logic               in_ready;
  logic               out_valid;
  logic               out_ready;
  logic [LEN-1:0]     sum;
  logic [IDXW-1:0]    idx;
  logic               found;
  logic               busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tree_scan_ctrl #(
    .NUM   (NUM),
    .LEN   (LEN),
    .CHUNK (CHUNK),
    .IDXW  (IDXW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in        (in_vec),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .idx       (idx),
    .found     (found),
    .busy      (busy)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [NUM*LEN-1:0] rand_odd_vec();
    logic [NUM*LEN-1:0] v;
    for (int i = 0; i < NUM; i++) v[i*LEN +: LEN] = LEN'($urandom) | 16'h0001;
    return v;
  endfunction

  function automatic logic [NUM*LEN-1:0] seq_odd_vec();
    logic [NUM*LEN-1:0] v;
    for (int i = 0; i < NUM; i++) v[i*LEN +: LEN] = LEN'(2*i + 1);
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction: accept, scan, optional backpressure, handshake.
  task automatic do_txn(input string name, input logic [NUM*LEN-1:0] v, input int hold_cycles);
    int          exp_i;
    logic [15:0] exp_sum;
    logic        exp_found;
    int          cycles;
    exp_i     = NUM - 1;
    exp_found = 1'b0;
    for (int i = NUM - 1; i >= 0; i--) begin
      if (v[i*LEN] == 1'b0) begin
        exp_i     = i;
        exp_found = 1'b1;
      end
    end
    exp_sum = v[exp_i*LEN +: LEN];

    check_val({name, ".in_ready_idle"}, 32'(in_ready), 32'd1);
    in_vec    = v;
    start     = 1'b1;
    out_ready = 1'b0;
    step();
    start  = 1'b0;
    in_vec = rand_odd_vec();
    check_val({name, ".busy_scan"}, 32'(busy), 32'd1);
    check_val({name, ".in_ready_scan"}, 32'(in_ready), 32'd0);
    cycles = 0;
    while (!out_valid && cycles < 40) begin
      step();
      cycles++;
    end
    check_val({name, ".latency"}, 32'(cycles), 32'(exp_i / CHUNK + 1));
    check_val({name, ".sum"}, 32'(sum), 32'(exp_sum));
    check_val({name, ".idx"}, 32'(idx), 32'(exp_i));
    check_val({name, ".found"}, 32'(found), 32'(exp_found));

    for (int h = 0; h < hold_cycles; h++) begin
      start  = 1'b1;
      in_vec = ~v;
      step();
      check_val({name, ".hold_valid"}, 32'(out_valid), 32'd1);
      check_val({name, ".hold_in_ready"}, 32'(in_ready), 32'd0);
      check_val({name, ".hold_sum"}, 32'(sum), 32'(exp_sum));
      check_val({name, ".hold_idx"}, 32'(idx), 32'(exp_i));
    end
    start     = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_val({name, ".post_valid"}, 32'(out_valid), 32'd0);
    check_val({name, ".post_busy"}, 32'(busy), 32'd0);
    check_val({name, ".post_in_ready"}, 32'(in_ready), 32'd1);
    check_val({name, ".post_sum"}, 32'(sum), 32'(exp_sum));
    check_val({name, ".post_idx"}, 32'(idx), 32'(exp_i));
    $display("txn %s idx=%0d sum=%04h found=%0b latency=%0d", name, idx, sum, found, cycles);
  endtask

  initial begin
    logic [NUM*LEN-1:0] v;
    rst       = 1'b1;
    start     = 1'b0;
    out_ready = 1'b0;
    in_vec    = '0;
    repeat (3) step();
    check_val("rst.in_ready", 32'(in_ready), 32'd1);
    check_val("rst.out_valid", 32'(out_valid), 32'd0);
    check_val("rst.busy", 32'(busy), 32'd0);
    check_val("rst.sum", 32'(sum), 32'd0);
    check_val("rst.idx", 32'(idx), 32'd0);
    check_val("rst.found", 32'(found), 32'd0);
    rst = 1'b0;
    step();

    do_txn("all_odd", seq_odd_vec(), 0);

    v = seq_odd_vec();
    v[5*LEN +: LEN] = 16'h1234;
    do_txn("e5", v, 0);

    v = seq_odd_vec();
    v[20*LEN +: LEN] = 16'h00A0;
    v[40*LEN +: LEN] = 16'h00C8;
    do_txn("e20_e40", v, 5);

    // A new scan after backpressure must use the new operands.
    v = rand_odd_vec();
    v[33*LEN +: LEN] = 16'hBEE2;
    do_txn("after_bp", v, 0);

    // Reset while scanning chunk 3 discards the pending result.
    in_vec = seq_odd_vec();
    start  = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_val("midrst.out_valid", 32'(out_valid), 32'd0);
    check_val("midrst.busy", 32'(busy), 32'd0);
    check_val("midrst.in_ready", 32'(in_ready), 32'd1);
    check_val("midrst.idx", 32'(idx), 32'd0);
    $display("txn midrst in_ready=%0b busy=%0b idx=%0d", in_ready, busy, idx);

    v = seq_odd_vec();
    v[63*LEN +: LEN] = 16'h0002;
    do_txn("e63", v, 0);

    v = seq_odd_vec();
    v[0 +: LEN] = 16'h0010;
    do_txn("snap0", v, 0);

    for (int t = 0; t < 24; t++) begin
      int nev;
      v   = rand_odd_vec();
      nev = $urandom_range(0, 3);
      for (int e = 0; e < nev; e++) begin
        v[$urandom_range(0, NUM-1)*LEN +: LEN] = LEN'($urandom) & 16'hFFFE;
      end
      do_txn($sformatf("rand%0d", t), v, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tree_scan_ctrl.md
Name: tree_scan_ctrl

Overview:
- Sequential controller that time-multiplexes one CHUNK-wide selection reduction across a wide NUM-entry operand vector, instead of instantiating a full NUM-input combinational selection tree.
- Selection rule, per entry pair (a,b): choose a if a[0]==0, else b.
- Reduced over entries 0..NUM-1, the result is the lowest-indexed entry with bit0==0; if no such entry exists, the result is entry NUM-1.
- Sits between an operand producer (start/in_ready) and a result consumer (out_valid/out_ready). Trades latency for area in the area/power study.

Parameters:
- NUM, 64, number of LEN-bit entries; must be a multiple of CHUNK.
- LEN, 16, entry width in bits.
- CHUNK, 8, entries evaluated per SCAN cycle; power of 2, 1..NUM.
- IDXW, $clog2(NUM), width of the result index.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; accepted only when in_ready=1.
- in  in  NUM*LEN  operands; entry i = in[(i+1)*LEN-1 : i*LEN]; snapshotted on the accept edge.
- in_ready  out  1  high only in IDLE.
- out_valid  out  1  high in HOLD.
- out_ready  in  1  consumer accepts the result when out_valid && out_ready.
- sum  out  LEN  selected entry value.
- idx  out  IDXW  index of the selected entry.
- found  out  1  1 if the selected entry has bit0==0.
- busy  out  1  high in SCAN or HOLD.

Behaviour:
- Reset: state=IDLE. in_ready=1. out_valid=0, sum=0, idx=0, found=0, busy=0. Chunk counter=0. Snapshot register contents are don't-care.
- rst has priority over every other input in every state.
  - Reset mid-SCAN or mid-HOLD: the next cycle is IDLE, and any pending result is discarded without handshake.
- States: IDLE, SCAN, HOLD.
- IDLE:
  - start=1 at edge E0: latch all of `in` into the snapshot register, clear the chunk counter k, go to SCAN.
  - start=0: stay in IDLE.
- SCAN:
  - Each cycle evaluates snapshot entries k*CHUNK .. k*CHUNK+CHUNK-1 with the chunk_select sub-module.
  - chunk_select returns: the lowest entry in the chunk with bit0==0 (value, local index, hit=1); if none, the last entry of the chunk with hit=0.
  - Terminating condition: hit=1, or k == NUM/CHUNK-1.
  - On the terminating condition: register sum, idx = k*CHUNK + local index, found = hit; go to HOLD.
  - Otherwise: k <= k+1 and stay in SCAN.
  - Early termination is mandatory: chunks after the first hit are never evaluated.
- Latency: if chunk k terminates, out_valid rises at edge E0+k+1. Best case is 1 cycle; worst case is NUM/CHUNK cycles.
- HOLD:
  - out_valid=1. sum, idx and found stay stable until the handshake.
  - out_valid && out_ready at an edge: go to IDLE; out_valid=0 after that edge. sum/idx/found keep their last values.
- start is ignored whenever in_ready=0 (SCAN or HOLD); it is not queued.
- Changes on `in` after the accept edge have no effect on the result.
- Arithmetic and width rules:
  - idx is computed at IDXW bits; k*CHUNK is a shift, never overflows.
  - The k counter is $clog2(NUM/CHUNK) bits, minimum 1 bit.
- Running-result merge is not required: termination on the first hit makes the last-evaluated chunk's result final.

Decomposition:
- Shared package tree_scan_pkg holds:
  - state encoding constants S_IDLE=2'd0, S_SCAN=2'd1, S_HOLD=2'd2;
  - a localparam function for the chunk count, NUM/CHUNK.
- One sub-module, chunk_select #(CHUNK, LEN): purely combinational priority selector of CHUNK entries. Outputs value, local index ($clog2(CHUNK) bits, minimum 1), hit.
- FSM, snapshot register and counter live in tree_scan_ctrl.

Test Plan (NUM=64, LEN=16, CHUNK=8):
- All entries odd, entry i = 2i+1, start at E0 → 8 SCAN cycles; out_valid at E0+8; sum=16'h007F, idx=63, found=0.
- Entry 5 = 16'h1234, all others odd → out_valid at E0+1; sum=16'h1234, idx=5, found=1; chunks 1..7 never evaluated (k stays 0).
- Entries 20 = 16'h00A0 and 40 = 16'h00C8, all others odd → out_valid at E0+3; sum=16'h00A0, idx=20, found=1.
- Backpressure: out_ready=0 for 5 cycles while in HOLD, with start pulsed and `in` changed → outputs stable, in_ready=0, no new scan. out_ready=1 → next cycle IDLE, in_ready=1; a subsequent start yields a result from the new `in`.
- rst=1 during SCAN at k=3 (all entries odd) → next cycle IDLE, out_valid=0, busy=0, in_ready=1, idx=0. A fresh start with entry 63 = 16'h0002 gives idx=63, found=1, sum=16'h0002 at E0+8.
- Snapshot: start with entry 0 = 16'h0010, then drive entry 0 odd on the next cycle → result sum=16'h0010, idx=0, found=1.
